pipe_reg: RTL and testbench
===========================

PIPE_REG -- requirements
Module: pipe_reg

Interface
REQ-001 SHALL have parameter DATA_W, default 64, the payload width in bits.
REQ-002 SHALL have parameter BUBBLE, default 0 (DATA_W wide), the value driven on out_data when no entry is valid.
REQ-003 SHALL have parameter CNT_W, default 16, the width of the statistics counters.
REQ-004 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-005 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-006 SHALL have port in_valid  input  1  upstream offers in_data.
REQ-007 SHALL have port in_ready  output  1  block accepts in_data this cycle.
REQ-008 SHALL have port in_data  input  DATA_W  upstream payload.
REQ-009 SHALL have port out_valid  output  1  out_data holds a valid entry.
REQ-010 SHALL have port out_ready  input  1  downstream consumes this cycle; low means stall.
REQ-011 SHALL have port out_data  output  DATA_W  head entry, or BUBBLE when empty.
REQ-012 SHALL have port flush  input  1  discard all held entries and any same-cycle input.
REQ-013 SHALL have port occupancy  output  2  entry count, 0..2.
REQ-014 SHALL have port stall_cnt  output  CNT_W  count of stall cycles.
REQ-015 SHALL have port flush_cnt  output  CNT_W  count of flush cycles.

Function
REQ-016 SHALL implement a 2-entry skid buffer with states EMPTY, ONE and TWO, consisting of a head register and a skid register.
REQ-017 SHALL define in_fire as in_valid & in_ready, and out_fire as out_valid & out_ready.
REQ-018 SHALL drive in_ready = (state != TWO), decoded from registered state only, with no combinational path from out_ready.
REQ-019 SHALL drive out_valid = (state != EMPTY), and out_data = head when out_valid is 1, else BUBBLE.
REQ-020 SHALL, in EMPTY: on in_fire, load head and go to ONE; otherwise remain in EMPTY.
REQ-021 SHALL, in ONE: on in_fire & !out_fire, load skid and go to TWO.
REQ-022 SHALL, in ONE: on in_fire & out_fire, load head with in_data and stay in ONE.
REQ-023 SHALL, in ONE: on out_fire only, go to EMPTY.
REQ-024 SHALL, in TWO: on out_fire, move skid into head and go to ONE; otherwise hold both entries.
REQ-025 SHALL give a latency of 1 cycle from in_fire to out_valid when starting in EMPTY.
REQ-026 SHALL deliver entries in strict FIFO order with no loss or duplication.
REQ-027 SHALL give flush the highest priority: on the next edge, state becomes EMPTY and same-cycle in_fire data is dropped.
REQ-028 SHALL NOT count a same-cycle out_fire during flush as a lost entry; downstream has already sampled it.
REQ-029 SHALL drive occupancy as 0, 1 or 2 for EMPTY, ONE or TWO respectively.
REQ-030 SHALL increment stall_cnt on every cycle with out_valid & !out_ready, saturating at all-ones.
REQ-031 SHALL increment flush_cnt on every cycle with flush high, saturating at all-ones.

Reset
REQ-032 SHALL, on rst high at a clock edge, set state to EMPTY, clear head and skid to BUBBLE, and clear stall_cnt and flush_cnt to 0.
REQ-033 SHALL give reset precedence over flush and any transfer, including a reset asserted mid-transfer.
REQ-034 SHALL hold in_ready=1, out_valid=0, out_data=BUBBLE and occupancy=0 in the cycle after reset.

Configuration
REQ-035 SHALL, with macro PIPE_REG_STATS_EN defined, implement the counters per REQ-030 and REQ-031.
REQ-036 SHALL, without PIPE_REG_STATS_EN, keep the stall_cnt and flush_cnt ports and tie them to constant 0, with no counter flops synthesised.

Verification
REQ-037 SHALL cover: reset, then in_valid=1 with in_data=0x11 and out_ready=1 -> out_valid=1 and out_data=0x11 one cycle later; occupancy=1.
REQ-038 SHALL cover: out_ready=0 while pushing 0xA1, then 0xA2 -> occupancy=2 and in_ready=0; then out_ready=1 -> outputs 0xA1, then 0xA2, in order.
REQ-039 SHALL cover: in TWO, assert flush with in_valid=1 and in_data=0xFF -> next cycle out_valid=0, out_data=BUBBLE, occupancy=0; 0xFF is never output; flush_cnt=1 (STATS_EN).
REQ-040 SHALL cover: continuous in_valid and out_ready with in_data 1..100 -> one output per cycle, 1..100 in order, occupancy constant at 1.
REQ-041 SHALL cover: CNT_W=4 with out_valid=1 and out_ready=0 for 20 cycles -> stall_cnt saturates at 15; without PIPE_REG_STATS_EN, stall_cnt stays 0.
REQ-042 SHALL cover: rst and flush asserted together in TWO -> next cycle EMPTY and both counters 0.

Source files
------------

// File: rtl/pipe_reg.sv
// rtl/pipe_reg.sv - two-entry skid buffer pipeline register with stall/flush statistics
// Define PIPE_REG_STATS_EN to build the saturating stall_cnt/flush_cnt counters; otherwise they read 0.
module pipe_reg #(
   parameter int                DATA_W = 64,
   parameter logic [DATA_W-1:0] BUBBLE = '0,
   parameter int                CNT_W  = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_data,
   input  logic              flush,
   output logic [1:0]        occupancy,
   output logic [CNT_W-1:0]  stall_cnt,
   output logic [CNT_W-1:0]  flush_cnt
);

   localparam logic [1:0] S_EMPTY = 2'd0;
   localparam logic [1:0] S_ONE   = 2'd1;
   localparam logic [1:0] S_TWO   = 2'd2;

   logic [1:0]        state;
   logic [DATA_W-1:0] head;
   logic [DATA_W-1:0] skid;
   logic              in_fire;
   logic              out_fire;

   // Handshake outputs depend only on registered state, never on out_ready.
   assign in_ready  = (state != S_TWO);
   assign out_valid = (state != S_EMPTY);
   assign out_data  = out_valid ? head : BUBBLE;
   assign in_fire   = in_valid & in_ready;
   assign out_fire  = out_valid & out_ready;

   always_comb begin
      occupancy = 2'd0;
      case (state)
         S_ONE:   occupancy = 2'd1;
         S_TWO:   occupancy = 2'd2;
         default: occupancy = 2'd0;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= S_EMPTY;
         head  <= BUBBLE;
         skid  <= BUBBLE;
      end else if (flush) begin
         state <= S_EMPTY;
      end else begin
         case (state)
            S_EMPTY: begin
               if (in_fire) begin
                  head  <= in_data;
                  state <= S_ONE;
               end
            end
            S_ONE: begin
               if (in_fire && !out_fire) begin
                  skid  <= in_data;
                  state <= S_TWO;
               end else if (in_fire && out_fire) begin
                  head <= in_data;
               end else if (out_fire) begin
                  state <= S_EMPTY;
               end
            end
            S_TWO: begin
               if (out_fire) begin
                  head  <= skid;
                  state <= S_ONE;
               end
            end
            default: state <= S_EMPTY;
         endcase
      end
   end

`ifdef PIPE_REG_STATS_EN
   logic [CNT_W-1:0] stall_q;
   logic [CNT_W-1:0] flush_q;

   // Both counters stick at all-ones rather than wrapping.
   always_ff @(posedge clk) begin
      if (rst) begin
         stall_q <= '0;
         flush_q <= '0;
      end else begin
         if (out_valid && !out_ready && (stall_q != '1))
            stall_q <= stall_q + CNT_W'(1);
         if (flush && (flush_q != '1))
            flush_q <= flush_q + CNT_W'(1);
      end
   end

   assign stall_cnt = stall_q;
   assign flush_cnt = flush_q;
`else
   assign stall_cnt = '0;
   assign flush_cnt = '0;
`endif

endmodule

// File: tb/tb_pipe_reg.sv
// tb/tb_pipe_reg.sv - self-checking bench for pipe_reg against a queue-based reference model
// Expected counter values follow PIPE_REG_STATS_EN when it is defined for the build.
module tb_pipe_reg;

   localparam int               DATA_W = 8;
   localparam int               CNT_W  = 4;
   localparam logic [7:0]       BUBBLE = 8'hEE;
   localparam int               CMAX   = (1 << CNT_W) - 1;
`ifdef PIPE_REG_STATS_EN
   localparam bit               STATS  = 1'b1;
`else
   localparam bit               STATS  = 1'b0;
`endif

   logic             clk = 1'b0;
   logic             rst, flush, in_valid, out_ready;
   logic [7:0]       in_data;
   logic             in_ready, out_valid;
   logic [7:0]       out_data;
   logic [1:0]       occupancy;
   logic [CNT_W-1:0] stall_cnt, flush_cnt;

   int n_cmp = 0;
   int n_bad = 0;
   bit checking = 1'b0;

   logic [7:0] mq[$];
   int         m_stall = 0;
   int         m_flush = 0;

   always #5 clk = ~clk;

   pipe_reg #(.DATA_W(DATA_W), .BUBBLE(BUBBLE), .CNT_W(CNT_W)) dut (
      .clk(clk), .rst(rst),
      .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
      .flush(flush), .occupancy(occupancy),
      .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference: a FIFO of at most two entries.
   always @(posedge clk) begin
      bit ifire, ofire;
      if (rst) begin
         mq.delete();
         m_stall = 0;
         m_flush = 0;
      end else begin
         ifire = in_valid && (mq.size() < 2);
         ofire = (mq.size() > 0) && out_ready;
         if (STATS) begin
            if ((mq.size() > 0) && !out_ready && (m_stall < CMAX)) m_stall++;
            if (flush && (m_flush < CMAX)) m_flush++;
         end
         if (flush) mq.delete();
         else begin
            if (ofire) void'(mq.pop_front());
            if (ifire) mq.push_back(in_data);
         end
      end
   end

   always @(negedge clk) begin
      if (checking) begin
         chk("in_ready",  32'(in_ready),  32'(mq.size() < 2));
         chk("out_valid", 32'(out_valid), 32'(mq.size() > 0));
         chk("out_data",  32'(out_data),  32'((mq.size() > 0) ? mq[0] : BUBBLE));
         chk("occupancy", 32'(occupancy), 32'(mq.size()));
         chk("stall_cnt", 32'(stall_cnt), 32'(m_stall));
         chk("flush_cnt", 32'(flush_cnt), 32'(m_flush));
      end
   end

   task automatic cycle(input logic r, input logic f, input logic iv,
                        input logic [7:0] d, input logic ordy);
      rst = r; flush = f; in_valid = iv; in_data = d; out_ready = ordy;
      @(posedge clk);
      @(negedge clk);
   endtask

   initial begin
      cycle(1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
      checking = 1'b1;

      chk("rst_in_ready",  32'(in_ready),  32'd1);
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_out_data",  32'(out_data),  32'hEE);
      chk("rst_occ",       32'(occupancy), 32'd0);

      cycle(1'b0, 1'b0, 1'b1, 8'h11, 1'b1);
      chk("first_valid", 32'(out_valid), 32'd1);
      chk("first_data",  32'(out_data),  32'h11);
      chk("first_occ",   32'(occupancy), 32'd1);

      cycle(1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
      cycle(1'b0, 1'b0, 1'b1, 8'hA1, 1'b0);
      cycle(1'b0, 1'b0, 1'b1, 8'hA2, 1'b0);
      chk("two_occ",      32'(occupancy), 32'd2);
      chk("two_in_ready", 32'(in_ready),  32'd0);
      chk("two_head",     32'(out_data),  32'hA1);
      cycle(1'b0, 1'b0, 1'b0, 8'h00, 1'b1);
      chk("drain_a2",     32'(out_data),  32'hA2);
      cycle(1'b0, 1'b0, 1'b0, 8'h00, 1'b1);
      chk("drain_empty",  32'(out_valid), 32'd0);

      cycle(1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
      cycle(1'b0, 1'b0, 1'b1, 8'h01, 1'b0);
      cycle(1'b0, 1'b0, 1'b1, 8'h02, 1'b0);
      cycle(1'b0, 1'b1, 1'b1, 8'hFF, 1'b0);
      chk("flush_valid", 32'(out_valid), 32'd0);
      chk("flush_data",  32'(out_data),  32'hEE);
      chk("flush_occ",   32'(occupancy), 32'd0);
      chk("flush_cnt1",  32'(flush_cnt), STATS ? 32'd1 : 32'd0);
      cycle(1'b0, 1'b0, 1'b0, 8'h00, 1'b1);
      chk("no_ff_out",   32'(out_valid), 32'd0);

      cycle(1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
      for (int i = 1; i <= 100; i++) begin
         cycle(1'b0, 1'b0, 1'b1, 8'(i), 1'b1);
         chk("stream_data", 32'(out_data),  32'(i));
         chk("stream_occ",  32'(occupancy), 32'd1);
      end

      cycle(1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
      cycle(1'b0, 1'b0, 1'b1, 8'h5A, 1'b0);
      for (int i = 0; i < 20; i++) cycle(1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
      chk("stall_sat", 32'(stall_cnt), STATS ? 32'd15 : 32'd0);

      cycle(1'b0, 1'b0, 1'b1, 8'h5B, 1'b0);
      cycle(1'b0, 1'b1, 1'b0, 8'h00, 1'b0);
      cycle(1'b0, 1'b0, 1'b1, 8'h61, 1'b0);
      cycle(1'b0, 1'b0, 1'b1, 8'h62, 1'b0);
      chk("pre_rf_occ", 32'(occupancy), 32'd2);
      cycle(1'b1, 1'b1, 1'b1, 8'h63, 1'b1);
      chk("rf_occ",   32'(occupancy), 32'd0);
      chk("rf_stall", 32'(stall_cnt), 32'd0);
      chk("rf_flush", 32'(flush_cnt), 32'd0);

      for (int i = 0; i < 3000; i++) begin
         cycle(($urandom_range(0, 199) == 0),
               ($urandom_range(0, 15) == 0),
               ($urandom_range(0, 3) != 0),
               8'($urandom),
               ($urandom_range(0, 2) != 0));
      end

      checking = 1'b0;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
